// File: rtl/uart_rx_pkg.sv
// Shared UART constants: 8N1 framing and the bit-period helper used by rx and tx.
package uart_rx_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;  // start + 8 data + stop

  // Clock cycles per bit; must land in 4..65535 to fit the 16-bit bit timer.
  function automatic int bps_cnt(input int clk_fre, input int bps);
    return clk_fre / bps;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the async RX pin with falling-edge detect.
// Flops reset high so a line idling high never looks like a start edge.
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rxd,
  output logic line,
  output logic fall
);

  logic s1, s2, s3;

  // Shift the raw pin through three flops; s1 absorbs metastability.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rxd;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign line = s2;
  assign fall = s3 & ~s2;

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: validates the start bit at mid-bit, samples data and
// stop at bit centres, and strobes each good byte (or a framing error).
//
// state | meaning
// IDLE  | waiting for a falling edge on the synchronised line
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling 8 data bits, LSB first, one per bit period
// STOP  | sampling the stop bit; high = good byte, low = frame error
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BPS     = 9_600,
  parameter int CLK_FRE = 200_000_000
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic                 uart_rxd,
  output logic [DATA_BITS-1:0] uart_rx_data,
  output logic                 uart_rx_done,
  output logic                 uart_rx_frame_err,
  output logic                 uart_rx_busy
);

  localparam int BPS_CNT = bps_cnt(CLK_FRE, BPS);
  localparam int HALF    = BPS_CNT >> 1;
  localparam logic [15:0] CNT_LAST  = 16'(BPS_CNT - 1);
  localparam logic [15:0] HALF_LAST = 16'(HALF - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [15:0]          clk_cnt, clk_cnt_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 done_nxt, err_nxt;
  logic                 line, fall;

  uart_rx_sync u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rxd       (uart_rxd),
    .line      (line),
    .fall      (fall)
  );

  // State, timers, shift register and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state             <= IDLE;
      clk_cnt           <= '0;
      bit_cnt           <= '0;
      shift             <= '0;
      uart_rx_data      <= '0;
      uart_rx_done      <= 1'b0;
      uart_rx_frame_err <= 1'b0;
    end else begin
      state             <= state_nxt;
      clk_cnt           <= clk_cnt_nxt;
      bit_cnt           <= bit_cnt_nxt;
      shift             <= shift_nxt;
      uart_rx_data      <= data_nxt;
      uart_rx_done      <= done_nxt;
      uart_rx_frame_err <= err_nxt;
    end
  end

  // Next-state, bit timing and sampling decisions.
  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt + 16'd1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = uart_rx_data;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (fall) state_nxt = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          state_nxt   = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt        = '0;
          shift_nxt[bit_cnt] = line;
          bit_cnt_nxt        = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end
      end
      STOP: begin
        if (clk_cnt == CNT_LAST) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (line) begin
            data_nxt = shift;
            done_nxt = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign uart_rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at BPS_CNT = 16, HALF = 8.
module tb_uart_rx;
  import uart_rx_pkg::*;

  localparam int BIT = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       uart_rxd  = 1'b1;
  logic [7:0] uart_rx_data;
  logic       uart_rx_done, uart_rx_frame_err, uart_rx_busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic       done;
    logic       err;
    logic [7:0] data;
    int         cyc;
  } obs_t;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  obs_t       obs_q[$];
  int         obs_rd = 0;
  exp_t       exp_q[$];
  logic [7:0] model_data = 8'h00;

  uart_rx #(.BPS(10), .CLK_FRE(160)) dut (
    .sys_clk           (sys_clk),
    .sys_rst_n         (sys_rst_n),
    .uart_rxd          (uart_rxd),
    .uart_rx_data      (uart_rx_data),
    .uart_rx_done      (uart_rx_done),
    .uart_rx_frame_err (uart_rx_frame_err),
    .uart_rx_busy      (uart_rx_busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Record every output strobe with the cycle it appeared in.
  always @(negedge sys_clk)
    if (uart_rx_done || uart_rx_frame_err)
      obs_q.push_back('{uart_rx_done, uart_rx_frame_err, uart_rx_data, cyc});

  task automatic drive_bit(input logic v);
    uart_rxd = v;
    repeat (BIT) @(negedge sys_clk);
  endtask

  // Sends one frame and pushes its expected outcome; t0 is the cycle number
  // of the first edge that samples the start bit low.
  task automatic send_frame(input logic [7:0] d, input logic stop, output int t0);
    t0 = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (stop) begin
      exp_q.push_back('{1'b0, d});
      model_data = d;
    end else begin
      exp_q.push_back('{1'b1, model_data});
    end
    drive_bit(stop);
  endtask

  // Pops n expected results and compares them with the recorded strobes.
  task automatic check_events(input int n, input string name, output int c0, output int c1);
    obs_t ev;
    exp_t ex;
    c0 = 0;
    c1 = 0;
    for (int w = 0; w < 400 && obs_q.size() < obs_rd + n; w++) @(negedge sys_clk);
    for (int i = 0; i < n; i++) begin
      ex = exp_q.pop_front();
      tests++;
      if (obs_rd >= obs_q.size()) begin
        fails++;
        $display("FAIL %s[%0d]: no strobe seen, expected err=%0b data=%02h", name, i, ex.err, ex.data);
      end else begin
        ev = obs_q[obs_rd];
        obs_rd++;
        if (i == 0) c0 = ev.cyc;
        c1 = ev.cyc;
        if ({ev.done, ev.err, ev.data} !== {~ex.err, ex.err, ex.data}) begin
          fails++;
          $display("FAIL %s[%0d]: got done=%0b err=%0b data=%02h, expected done=%0b err=%0b data=%02h",
                   name, i, ev.done, ev.err, ev.data, ~ex.err, ex.err, ex.data);
        end
      end
    end
    repeat (4) @(negedge sys_clk);
    tests++;
    if (obs_q.size() !== obs_rd) begin
      fails++;
      $display("FAIL %s_extra: got %0d extra strobes, expected 0", name, obs_q.size() - obs_rd);
      obs_rd = obs_q.size();
    end
  endtask

  task automatic check_idle_outputs(input string name);
    tests++;
    if ({uart_rx_data, uart_rx_done, uart_rx_frame_err, uart_rx_busy} !== 11'h0) begin
      fails++;
      $display("FAIL %s: got data=%02h done=%0b err=%0b busy=%0b, expected all 0",
               name, uart_rx_data, uart_rx_done, uart_rx_frame_err, uart_rx_busy);
    end
  endtask

  task automatic test_reset();
    check_idle_outputs("reset_values");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_single_frame();
    int t0, c0, c1;
    send_frame(8'h55, 1'b1, t0);
    check_events(1, "single", c0, c1);
    // 155th edge counting the first low-sample edge as edge 1
    tests++;
    if (c0 - t0 !== 154) begin
      fails++;
      $display("FAIL single_latency: got %0d, expected 154", c0 - t0);
    end
    tests++;
    if (uart_rx_busy !== 1'b0) begin
      fails++;
      $display("FAIL single_busy_after: got %0b, expected 0", uart_rx_busy);
    end
  endtask

  task automatic test_start_glitch();
    int n = 0;
    uart_rxd = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 4) uart_rxd = 1'b1;
      @(negedge sys_clk);
      if (uart_rx_busy) n++;
    end
    tests++;
    if (n !== 8) begin
      fails++;
      $display("FAIL glitch_busy_cycles: got %0d, expected 8", n);
    end
    tests++;
    if (obs_q.size() !== obs_rd) begin
      fails++;
      $display("FAIL glitch_no_strobe: got %0d strobes, expected 0", obs_q.size() - obs_rd);
      obs_rd = obs_q.size();
    end
    tests++;
    if (uart_rx_data !== model_data) begin
      fails++;
      $display("FAIL glitch_data_held: got %02h, expected %02h", uart_rx_data, model_data);
    end
  endtask

  task automatic test_frame_err();
    int t0, c0, c1;
    send_frame(8'hA3, 1'b0, t0);
    uart_rxd = 1'b1;
    check_events(1, "frame_err", c0, c1);
    tests++;
    if (uart_rx_data !== 8'h55) begin
      fails++;
      $display("FAIL frame_err_data_held: got %02h, expected 55", uart_rx_data);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1, c0, c1;
    send_frame(8'h00, 1'b1, t0);
    send_frame(8'hFF, 1'b1, t1);
    check_events(2, "back_to_back", c0, c1);
    tests++;
    if (c1 - c0 !== 160) begin
      fails++;
      $display("FAIL back_to_back_spacing: got %0d, expected 160", c1 - c0);
    end
  endtask

  task automatic test_break();
    int c0, c1;
    uart_rxd = 1'b0;
    exp_q.push_back('{1'b1, model_data});
    repeat (200) @(negedge sys_clk);
    check_events(1, "break", c0, c1);
    uart_rxd = 1'b1;
    repeat (20) @(negedge sys_clk);
    tests++;
    if (uart_rx_busy !== 1'b0 || obs_q.size() !== obs_rd) begin
      fails++;
      $display("FAIL break_recover: got busy=%0b strobes=%0d, expected busy=0 strobes=0",
               uart_rx_busy, obs_q.size() - obs_rd);
      obs_rd = obs_q.size();
    end
  endtask

  task automatic test_reset_mid_frame();
    int t0, c0, c1;
    logic [7:0] d = 8'h3C;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    uart_rxd = d[4];
    repeat (5) @(negedge sys_clk);
    tests++;
    if (uart_rx_busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_busy_before: got %0b, expected 1", uart_rx_busy);
    end
    #2 sys_rst_n = 1'b0;
    model_data = 8'h00;
    #1 check_idle_outputs("reset_mid_immediate");
    uart_rxd = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    send_frame(d, 1'b1, t0);
    check_events(1, "reset_mid_next_frame", c0, c1);
  endtask

  // Bench-side transmitter: serialises a full 8N1 frame vector LSB first.
  task automatic test_loopback();
    int c0, c1;
    logic [FRAME_BITS-1:0] frame;
    frame = {1'b1, 8'h5A, 1'b0};
    exp_q.push_back('{1'b0, 8'h5A});
    model_data = 8'h5A;
    for (int i = 0; i < FRAME_BITS; i++) begin
      uart_rxd = frame[i];
      repeat (BIT) @(negedge sys_clk);
    end
    uart_rxd = 1'b1;
    check_events(1, "loopback", c0, c1);
    tests++;
    if (uart_rx_data !== 8'h5A) begin
      fails++;
      $display("FAIL loopback_data: got %02h, expected 5a", uart_rx_data);
    end
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    test_reset();
    test_single_frame();
    test_start_glitch();
    test_frame_err();
    test_back_to_back();
    test_break();
    test_reset_mid_frame();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Done and frame error are mutually exclusive strobes.
  always @(negedge sys_clk)
    assert (!(uart_rx_done && uart_rx_frame_err))
      else $error("FAIL strobe_exclusive: done and frame_err both high");

endmodule
